// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the way-halting cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL_REQ,
        REFILL_WAIT,
        RESPOND
    } state_t;

    function automatic int calc_idx_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int sets);
        return addr_w - calc_idx_w(sets) - 2;
    endfunction

endpackage

// File: rtl/cache_way_cmp.sv
// Per-way lookup compare: optional halt-tag pre-check (WAY_HALT_EN) gating the full tag compare.
module cache_way_cmp
    import cache_pkg::*;
#(
    parameter int TAG_W = 27
`ifdef WAY_HALT_EN
    ,
    parameter int HALT_BITS = 4
`endif
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] way_tag,
`ifdef WAY_HALT_EN
    input  logic [HALT_BITS-1:0] halt_tag,
`endif
    input  logic [TAG_W-1:0] req_tag,
    output logic             en,
    output logic             hit
);

`ifdef WAY_HALT_EN
    // Cheap narrow compare first; the wide compare only matters for enabled ways.
    assign en = valid && (halt_tag == req_tag[HALT_BITS-1:0]);
`else
    assign en = valid;
`endif

    assign hit = en && (way_tag == req_tag);

endmodule

// File: rtl/way_halt_cache_ctrl.sv
// N-way set-associative write-back cache, one word per line, round-robin replacement.
// Define WAY_HALT_EN to store halt tags and disable mismatching ways before the full tag compare.
module way_halt_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SETS      = 8,
    parameter int WAYS      = 4,
    parameter int HALT_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic [WAYS-1:0]   way_en,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    localparam int IDX_W = calc_idx_w(SETS);
    localparam int TAG_W = calc_tag_w(ADDR_W, SETS);
    localparam int WAY_W = $clog2(WAYS);

    state_t state_reg, state_next;

    logic              we_reg;
    logic [ADDR_W-3:0] line_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              hit_reg;
    logic [WAY_W-1:0]  victim_reg;

    logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
    logic [DATA_W-1:0] data_arr  [SETS][WAYS];
    logic              valid_arr [SETS][WAYS];
    logic              dirty_arr [SETS][WAYS];
    logic [WAY_W-1:0]  rr_ptr    [SETS];
`ifdef WAY_HALT_EN
    logic [HALT_BITS-1:0] halt_arr [SETS][WAYS];
`endif

    logic [IDX_W-1:0] set_idx;
    logic [TAG_W-1:0] req_tag;
    logic [WAYS-1:0]  en_vec;
    logic [WAYS-1:0]  hit_vec;
    logic             any_hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_sel;
    logic             refill_done;

    assign set_idx     = line_reg[IDX_W-1:0];
    assign req_tag     = line_reg[ADDR_W-3:IDX_W];
    assign any_hit     = |hit_vec;
    assign refill_done = (state_reg == REFILL_WAIT) && mem_resp_valid;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            cache_way_cmp #(
                .TAG_W     (TAG_W)
`ifdef WAY_HALT_EN
                ,
                .HALT_BITS (HALT_BITS)
`endif
            ) u_cmp (
                .valid    (valid_arr[set_idx][gi]),
                .way_tag  (tag_arr[set_idx][gi]),
`ifdef WAY_HALT_EN
                .halt_tag (halt_arr[set_idx][gi]),
`endif
                .req_tag  (req_tag),
                .en       (en_vec[gi]),
                .hit      (hit_vec[gi])
            );
        end
    endgenerate

    // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        hit_way    = '0;
        victim_sel = rr_ptr[set_idx];
        for (int i = 0; i < WAYS; i++) begin
            if (hit_vec[i]) hit_way = i[WAY_W-1:0];
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_arr[set_idx][i]) victim_sel = i[WAY_W-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:        if (req_valid) state_next = LOOKUP;
            LOOKUP: begin
                if (any_hit)
                    state_next = RESPOND;
                else if (valid_arr[set_idx][victim_sel] && dirty_arr[set_idx][victim_sel])
                    state_next = WRITEBACK;
                else
                    state_next = REFILL_REQ;
            end
            WRITEBACK:   if (mem_req_ready) state_next = REFILL_REQ;
            REFILL_REQ:  if (mem_req_ready) state_next = REFILL_WAIT;
            REFILL_WAIT: if (mem_resp_valid) state_next = RESPOND;
            RESPOND:     state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state_reg == IDLE);
        resp_valid    = (state_reg == RESPOND);
        resp_rdata    = '0;
        resp_hit      = 1'b0;
        way_en        = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state_reg)
            LOOKUP: way_en = en_vec;
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_arr[set_idx][victim_reg], set_idx, 2'b00};
                mem_req_wdata = data_arr[set_idx][victim_reg];
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {line_reg, 2'b00};
            end
            RESPOND: begin
                resp_rdata = rdata_reg;
                resp_hit   = hit_reg;
            end
            default: ;
        endcase
    end

    // Control state and valid/dirty/pointer bookkeeping; these are the only arrays reset clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            line_reg   <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            hit_reg    <= 1'b0;
            victim_reg <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_arr[s][w] <= 1'b0;
                    dirty_arr[s][w] <= 1'b0;
                end
            end
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        line_reg  <= req_addr[ADDR_W-1:2];
                        wdata_reg <= req_wdata;
                    end
                end
                LOOKUP: begin
                    victim_reg <= victim_sel;
                    hit_reg    <= any_hit;
                    if (any_hit) begin
                        rdata_reg <= we_reg ? wdata_reg : data_arr[set_idx][hit_way];
                        if (we_reg) dirty_arr[set_idx][hit_way] <= 1'b1;
                    end
                end
                REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_arr[set_idx][victim_reg] <= 1'b1;
                        dirty_arr[set_idx][victim_reg] <= we_reg;
                        rr_ptr[set_idx]                <= rr_ptr[set_idx] + 1'b1;
                        rdata_reg <= we_reg ? wdata_reg : mem_resp_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data payload; left uninitialised on reset since valid gates every use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_reg == LOOKUP && any_hit && we_reg)
                data_arr[set_idx][hit_way] <= wdata_reg;
            if (refill_done) begin
                tag_arr[set_idx][victim_reg]  <= req_tag;
                data_arr[set_idx][victim_reg] <= we_reg ? wdata_reg : mem_resp_rdata;
`ifdef WAY_HALT_EN
                halt_arr[set_idx][victim_reg] <= req_tag[HALT_BITS-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_way_halt_cache_ctrl.sv
// Directed bench for way_halt_cache_ctrl: cache/memory model plus per-cycle output compare.
module tb_way_halt_cache_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_hit;
    logic [3:0]  way_en;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    way_halt_cache_ctrl #(
        .ADDR_W(32), .DATA_W(32), .SETS(8), .WAYS(4), .HALT_BITS(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .way_en(way_en),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Cache model: contents per set/way, round-robin pointers, and a backing memory.
    logic [26:0] m_tag   [8][4];
    logic [31:0] m_data  [8][4];
    bit          m_valid [8][4];
    bit          m_dirty [8][4];
    int          m_rr    [8];
    logic [31:0] mem     [int];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a ^ 32'h5A5A0000;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
    endtask

    bit          started = 0;
    bit          active  = 0;
    bit          resp_seen;
    int          acc_cyc = -100;
    bit          exp_hit;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_way_en;
    logic [31:0] last_rdata;
    bit          last_hit;
    logic [3:0]  last_way_en;
    logic [31:0] last_wb_addr;
    logic [31:0] last_wb_data;

    // Compare process: way_en every cycle, response contents and hit latency.
    initial forever begin
        @(negedge clk);
        if (started && !reset) begin
            if (active && cyc == acc_cyc) begin
                check(way_en == exp_way_en, "way_en_lookup", {28'd0, way_en}, {28'd0, exp_way_en});
                last_way_en = way_en;
            end else begin
                check(way_en == 4'd0, "way_en_idle", {28'd0, way_en}, 32'd0);
            end
            if (resp_valid) begin
                check(active && !resp_seen, "resp_expected", 32'd1, {31'd0, active && !resp_seen});
                check(resp_rdata == exp_rdata, "resp_rdata", resp_rdata, exp_rdata);
                check(resp_hit == exp_hit, "resp_hit", {31'd0, resp_hit}, {31'd0, exp_hit});
                if (exp_hit)
                    check(cyc == acc_cyc + 1, "hit_latency", cyc - acc_cyc + 1, 32'd2);
                last_rdata = resp_rdata;
                last_hit   = resp_hit;
                resp_seen  = 1;
            end
        end
    end

    task automatic mem_handshake(input bit we, input logic [31:0] addr, input logic [31:0] data, input int delay);
        int w = 0;
        while (!mem_req_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check(mem_req_valid, "mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        for (int d = 0; d <= delay; d++) begin
            check(mem_req_we == we, "mem_req_we", {31'd0, mem_req_we}, {31'd0, we});
            check(mem_req_addr == addr, "mem_req_addr", mem_req_addr, addr);
            if (we) check(mem_req_wdata == data, "mem_req_wdata", mem_req_wdata, data);
            if (d < delay) begin
                @(posedge clk); #1;
            end
        end
        if (we) begin
            last_wb_addr = mem_req_addr;
            last_wb_data = mem_req_wdata;
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input int delay, input bit abort);
        int          s;
        logic [26:0] tag;
        bit          mhit;
        bit          wb;
        int          v;
        logic [31:0] wb_addr, wb_data, memval;
        s    = int'(addr[4:2]);
        tag  = addr[31:5];
        mhit = 0;
        wb   = 0;
        v    = 0;
        wb_addr = '0;
        wb_data = '0;
        memval  = '0;
        for (int w = 0; w < 4; w++) begin
`ifdef WAY_HALT_EN
            exp_way_en[w] = m_valid[s][w] && (m_tag[s][w][3:0] == tag[3:0]);
`else
            exp_way_en[w] = m_valid[s][w];
`endif
            if (m_valid[s][w] && m_tag[s][w] == tag) begin
                mhit = 1;
                v    = w;
            end
        end
        if (mhit) begin
            exp_rdata = we ? wd : m_data[s][v];
            if (we) begin
                m_data[s][v]  = wd;
                m_dirty[s][v] = 1;
            end
        end else begin
            v = m_rr[s];
            for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (m_valid[s][v] && m_dirty[s][v]) begin
                wb      = 1;
                wb_addr = {m_tag[s][v], addr[4:2], 2'b00};
                wb_data = m_data[s][v];
                mem[int'(wb_addr)] = wb_data;
            end
            memval        = mem_rd({addr[31:2], 2'b00});
            exp_rdata     = we ? wd : memval;
            m_tag[s][v]   = tag;
            m_data[s][v]  = exp_rdata;
            m_valid[s][v] = 1;
            m_dirty[s][v] = we;
            m_rr[s]       = (m_rr[s] + 1) % 4;
        end
        exp_hit   = mhit;
        resp_seen = 0;

        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        check(req_ready, "req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_cyc   = cyc;
        active    = 1;

        if (!mhit) begin
            if (wb) mem_handshake(1'b1, wb_addr, wb_data, delay);
            mem_handshake(1'b0, {addr[31:2], 2'b00}, 32'd0, delay);
            if (abort) begin
                active = 0;
                reset  = 1'b1;
                @(posedge clk); #1;
                reset  = 1'b0;
                model_reset();
                check(req_ready, "abort_req_ready", {31'd0, req_ready}, 32'd1);
                check(!mem_req_valid, "abort_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
                check(!resp_valid, "abort_resp_valid", {31'd0, resp_valid}, 32'd0);
                $display("txn we=%0d addr=%h aborted by reset in REFILL_WAIT", we, addr);
                return;
            end
            mem_resp_valid = 1'b1;
            mem_resp_rdata = memval;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end
        for (int i = 0; i < 20 && !resp_seen; i++) begin
            if (mhit) check(!mem_req_valid, "hit_no_mem_req", {31'd0, mem_req_valid}, 32'd0);
            @(posedge clk); #1;
        end
        check(resp_seen, "resp_seen", {31'd0, resp_seen}, 32'd1);
        active = 0;
        $display("txn we=%0d addr=%h wdata=%h rdata=%h hit=%0d way_en=%b wb=%0d",
                 we, addr, wd, last_rdata, last_hit, last_way_en, wb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1;

        check(req_ready == 1'b1, "rst_req_ready", {31'd0, req_ready}, 32'd1);
        check(resp_valid == 1'b0, "rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check(resp_hit == 1'b0, "rst_resp_hit", {31'd0, resp_hit}, 32'd0);
        check(resp_rdata == 32'd0, "rst_resp_rdata", resp_rdata, 32'd0);
        check(mem_req_valid == 1'b0, "rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check(mem_req_addr == 32'd0, "rst_mem_req_addr", mem_req_addr, 32'd0);
        check(way_en == 4'd0, "rst_way_en", {28'd0, way_en}, 32'd0);

        // Cold miss then hit on the same line.
        access(1'b0, 32'h0000_0100, 32'd0, 0, 1'b0);
        check(last_rdata == 32'h5A5A_0100 && !last_hit, "pin_cold_miss", last_rdata, 32'h5A5A_0100);
        access(1'b0, 32'h0000_0100, 32'd0, 0, 1'b0);
        check(last_rdata == 32'h5A5A_0100 && last_hit, "pin_repeat_hit", last_rdata, 32'h5A5A_0100);

        // Tags 8 and 24 share halt bits in set 0: two ways enabled, one hits.
        access(1'b0, 32'h0000_0300, 32'd0, 0, 1'b0);
        access(1'b0, 32'h0000_0100, 32'd0, 0, 1'b0);
        check(last_way_en == 4'b0011 && last_hit, "pin_two_enabled", {28'd0, last_way_en}, 32'h3);

        // Dirty line in way 0, then five new tags force a round-robin wrap and a write-back.
        access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0);
        check(last_rdata == 32'hDEAD_BEEF && last_hit, "pin_store_hit", last_rdata, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0500, 32'd0, 0, 1'b0);
        access(1'b0, 32'h0000_0700, 32'd0, 1, 1'b0);
        access(1'b0, 32'h0000_0900, 32'd0, 2, 1'b0);
        check(last_wb_addr == 32'h0000_0100, "pin_wb_addr", last_wb_addr, 32'h0000_0100);
        check(last_wb_data == 32'hDEAD_BEEF, "pin_wb_data", last_wb_data, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0B00, 32'd0, 0, 1'b0);
        access(1'b0, 32'h0000_0D00, 32'd0, 0, 1'b0);
        access(1'b0, 32'h0000_0100, 32'd0, 0, 1'b0);
        check(last_rdata == 32'hDEAD_BEEF && !last_hit, "pin_refill_after_wb", last_rdata, 32'hDEAD_BEEF);

        // Store miss allocates dirty, then hits.
        access(1'b1, 32'h0000_0104, 32'h1234_5678, 0, 1'b0);
        check(last_rdata == 32'h1234_5678 && !last_hit, "pin_store_miss", last_rdata, 32'h1234_5678);
        access(1'b0, 32'h0000_0104, 32'd0, 0, 1'b0);
        check(last_rdata == 32'h1234_5678 && last_hit, "pin_store_then_hit", last_rdata, 32'h1234_5678);

        // Stalled refill, then reset in REFILL_WAIT: dirty store data is lost.
        access(1'b0, 32'h0000_0204, 32'd0, 5, 1'b1);
        access(1'b0, 32'h0000_0104, 32'd0, 0, 1'b0);
        check(last_rdata == 32'h5A5A_0104 && !last_hit, "pin_after_reset_miss", last_rdata, 32'h5A5A_0104);
        access(1'b0, 32'h0000_0104, 32'd0, 0, 1'b0);
        check(last_hit, "pin_after_reset_hit", {31'd0, last_hit}, 32'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
